// File: rtl/graphite_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : graphite_cmd_fifo
// Purpose  : CPU-side command queue for the graphite rasterizer. The CPU
//            pushes 32-bit commands over a sel/wr/ack register bus; queued
//            commands are issued to graphite as an AXI-stream master.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 in   1   single system/pixel clock
//   reset_i             in   1   synchronous active-high reset
//   sel_i               in   1   bus access strobe, held until ack_o
//   wr_i                in   1   1 = write, 0 = read
//   addr_i              in   2   register index
//   data_i              in   32  write data
//   data_o              out  32  read data, valid while ack_o = 1
//   ack_o               out  1   one-cycle access acknowledge
//   cmd_axis_tvalid_o   out  1   command available
//   cmd_axis_tready_i   in   1   graphite accepts command
//   cmd_axis_tdata_o    out  32  command word (head of queue)
// Registers
//   0 W push / R 0
//   1 R {overflow, 14'b0, full, empty, level[14:0]}
//     W bit0 clears overflow, bit1 flushes (head kept if presented and not popped)
//   2 R pop count / W clear      (GRAPHITE_CMD_FIFO_STATS_EN only, else 0)
//   3 R level high-water / W re-arm (GRAPHITE_CMD_FIFO_STATS_EN only, else 0)
// Build option
//   GRAPHITE_CMD_FIFO_STATS_EN : enables the pop counter and high-water mark.
// ============================================================================
module graphite_cmd_fifo #(
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        sel_i,
  input  logic        wr_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        cmd_axis_tvalid_o,
  input  logic        cmd_axis_tready_i,
  output logic [31:0] cmd_axis_tdata_o
);

  localparam int                 PTR_W      = $clog2(DEPTH);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

  logic [31:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;

  logic        take;
  logic        full;
  logic        empty;
  logic        wr_reg0;
  logic        wr_reg1;
  logic        do_push;
  logic        do_pop;
  logic        do_flush;
  logic [31:0] status_word;
  logic [31:0] rd_mux;

`ifdef GRAPHITE_CMD_FIFO_STATS_EN
  logic [31:0]        pop_cnt_q, pop_cnt_d;
  logic [LEVEL_W-1:0] hwm_q, hwm_d;
  logic               wr_reg2;
  logic               wr_reg3;
`endif

  // --------------------------------------------------------------------------
  // Bus decode and FIFO next-state
  // --------------------------------------------------------------------------
  always_comb begin
    // An access is taken only while no ack is outstanding, so each access
    // produces exactly one side effect.
    take     = sel_i & ~ack_q;
    full     = (level_q == FULL_LEVEL);
    empty    = (level_q == '0);
    do_pop   = ~empty & cmd_axis_tready_i;
    wr_reg0  = take & wr_i & (addr_i == 2'd0);
    wr_reg1  = take & wr_i & (addr_i == 2'd1);
    // Full is judged on the current level: a same-cycle pop does not make room.
    do_push  = wr_reg0 & ~full;
    do_flush = wr_reg1 & data_i[1];

    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    level_d  = level_q + LEVEL_W'(do_push) - LEVEL_W'(do_pop);

    if (do_flush) begin
      if (!empty && !do_pop) begin
        // Head is on the bus and not yet accepted: keep it, drop the rest.
        level_d  = LEVEL_W'(1);
        wr_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        level_d  = '0;
        wr_ptr_d = rd_ptr_d;
      end
    end

    overflow_d = overflow_q;
    if (wr_reg0 && full) begin
      overflow_d = 1'b1;
    end else if (wr_reg1 && data_i[0]) begin
      overflow_d = 1'b0;
    end

`ifdef GRAPHITE_CMD_FIFO_STATS_EN
    wr_reg2   = take & wr_i & (addr_i == 2'd2);
    wr_reg3   = take & wr_i & (addr_i == 2'd3);
    pop_cnt_d = wr_reg2 ? 32'(do_pop) : pop_cnt_q + 32'(do_pop);
    if (wr_reg3) begin
      hwm_d = level_q;
    end else if (level_d > hwm_q) begin
      hwm_d = level_d;
    end else begin
      hwm_d = hwm_q;
    end
`endif

    status_word = {overflow_q, 14'b0, full, empty, 15'(level_q)};

    rd_mux = 32'd0;
    case (addr_i)
      2'd1:    rd_mux = status_word;
`ifdef GRAPHITE_CMD_FIFO_STATS_EN
      2'd2:    rd_mux = pop_cnt_q;
      2'd3:    rd_mux = 32'(hwm_q);
`endif
      default: rd_mux = 32'd0;
    endcase

    rdata_d = (take && !wr_i) ? rd_mux : 32'd0;
    ack_d   = take;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= 32'd0;
`ifdef GRAPHITE_CMD_FIFO_STATS_EN
      pop_cnt_q  <= 32'd0;
      hwm_q      <= '0;
`endif
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
`ifdef GRAPHITE_CMD_FIFO_STATS_EN
      pop_cnt_q  <= pop_cnt_d;
      hwm_q      <= hwm_d;
`endif
    end
  end

  // Storage needs no reset: entries are only observable through level_q.
  // A push never targets the head slot (refused when full), so the word
  // on the bus cannot change while it is stalled.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign ack_o             = ack_q;
  assign data_o            = rdata_q;
  assign cmd_axis_tvalid_o = ~empty;
  assign cmd_axis_tdata_o  = empty ? 32'd0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_graphite_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_graphite_cmd_fifo
// Purpose  : Self-checking bench for graphite_cmd_fifo. Bus accesses update a
//            reference queue of expected commands; an independent monitor
//            pops and compares on every accepted AXI beat and checks that a
//            stalled beat stays stable.
// Revision : 1.0 - initial release
// Build option: GRAPHITE_CMD_FIFO_STATS_EN selects the statistics checks.
// ============================================================================
module tb_graphite_cmd_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        wr;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          pop_stamp = -1;
  logic [31:0] exp_q [$];
  bit          exp_ovf  = 1'b0;
  bit          rand_done = 1'b0;

  graphite_cmd_fifo #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset_i           (rst),
    .sel_i             (sel),
    .wr_i              (wr),
    .addr_i            (addr),
    .data_i            (wdata),
    .data_o            (rdata),
    .ack_o             (ack),
    .cmd_axis_tvalid_o (tvalid),
    .cmd_axis_tready_i (tready),
    .cmd_axis_tdata_o  (tdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pop on each accepted beat, stability under stall.
  initial begin
    bit          prev_v = 1'b0;
    bit          prev_r = 1'b0;
    logic [31:0] prev_d = '0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v && !prev_r) begin
          chk("stall_valid", {31'd0, tvalid}, 32'd1);
          chk("stall_data", tdata, prev_d);
        end
        if (tvalid && tready) begin
          pop_stamp = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: actual=0x%08h required=none", tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", tdata, e);
          end
        end
        prev_v = tvalid;
        prev_r = tready;
        prev_d = tdata;
      end
    end
  end

  // One register access; the reference model is updated at the take cycle,
  // after the monitor has accounted for any pop on that same clock edge.
  task automatic bus(input bit w, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    bit popped_now;
    @(posedge clk); #1;
    sel = 1'b1; wr = w; addr = a; wdata = d;
    @(negedge clk); #1;
    popped_now = (pop_stamp == cyc);
    if (w && a == 2'd0) begin
      if (exp_q.size() + (popped_now ? 1 : 0) == DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(d);
    end
    if (w && a == 2'd1) begin
      if (d[1]) begin
        if (popped_now) exp_q.delete();
        else while (exp_q.size() > 1) void'(exp_q.pop_back());
      end
      if (d[0]) exp_ovf = 1'b0;
    end
    @(posedge clk); #1;
    sel = 1'b0;
    @(negedge clk);
    chk("ack", {31'd0, ack}, 32'd1);
    rd = rdata;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, d, dummy);
  endtask

  task automatic bus_rd_chk(input string name, input logic [1:0] a, input logic [31:0] req);
    logic [31:0] v;
    bus(1'b0, a, 32'd0, v);
    chk(name, v, req);
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(posedge clk); #1;
    tready = 1'b1;
    while ((exp_q.size() != 0 || tvalid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    tready = 1'b0;
    @(negedge clk);
    chk({name, "_timeout"}, {31'd0, n >= 200}, 32'd0);
    chk({name, "_left"}, exp_q.size(), 32'd0);
    chk({name, "_valid"}, {31'd0, tvalid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 32'd0; tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_data", rdata, 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_tvalid", {31'd0, tvalid}, 32'd0);
    chk("idle_ack", {31'd0, ack}, 32'd0);
    bus_rd_chk("status_empty", 2'd1, 32'h0000_8000);
    bus_rd_chk("reg0_read", 2'd0, 32'd0);

    // Single command, held stalled, then one pop.
    bus_wr(2'd0, 32'hA100_0001);
    chk("single_tvalid", {31'd0, tvalid}, 32'd1);
    chk("single_tdata", tdata, 32'hA100_0001);
    repeat (10) @(negedge clk);
    chk("single_held", tdata, 32'hA100_0001);
    @(posedge clk); #1;
    tready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    tready = 1'b0;
    @(negedge clk);
    chk("single_gone", {31'd0, tvalid}, 32'd0);
    bus_rd_chk("status_after_single", 2'd1, 32'h0000_8000);

    // Overfill by one, then drain at full rate.
    for (int i = 1; i <= DEPTH + 1; i++) bus_wr(2'd0, 32'(i));
    bus_rd_chk("status_overflow", 2'd1, 32'h8001_0010);
    @(posedge clk); #1;
    tready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("burst_valid", {31'd0, tvalid}, 32'd1);
    end
    @(posedge clk); #1;
    tready = 1'b0;
    @(negedge clk);
    chk("burst_end_valid", {31'd0, tvalid}, 32'd0);
    chk("burst_left", exp_q.size(), 32'd0);
    bus_wr(2'd1, 32'd1);
    bus_rd_chk("status_ovf_clear", 2'd1, 32'h0000_8000);

    // Flush keeps the presented head only.
    for (int i = 1; i <= 5; i++) bus_wr(2'd0, 32'hB000_0000 | 32'(i));
    bus_wr(2'd1, 32'd2);
    chk("flush_tvalid", {31'd0, tvalid}, 32'd1);
    chk("flush_tdata", tdata, 32'hB000_0001);
    bus_rd_chk("status_flush", 2'd1, 32'h0000_0001);
    drain("flush_drain");

    // Registers 2/3 without statistics: read 0, writes ignored.
`ifndef GRAPHITE_CMD_FIFO_STATS_EN
    bus_wr(2'd2, 32'hFFFF_FFFF);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_rd_chk("reg2_zero", 2'd2, 32'd0);
    bus_rd_chk("reg3_zero", 2'd3, 32'd0);
    bus_rd_chk("status_after_reg23", 2'd1, 32'h0000_8000);
`endif

    // Random back-pressure against a stream of pushes.
    fork
      begin
        for (int i = 0; i < 200; i++) bus_wr(2'd0, $urandom);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          tready = ($urandom_range(0, 2) == 0);
        end
      end
    join
    tready = 1'b0;
    drain("random_drain");
    bus_rd_chk("status_random", 2'd1, {exp_ovf, 14'd0, 1'b0, 1'b1, 15'd0});
    bus_wr(2'd1, 32'd1);
    bus_rd_chk("status_random_clr", 2'd1, 32'h0000_8000);

`ifdef GRAPHITE_CMD_FIFO_STATS_EN
    bus_wr(2'd2, 32'd0);
    for (int i = 1; i <= 7; i++) bus_wr(2'd0, 32'hC000_0000 | 32'(i));
    drain("stats_drain");
    bus_rd_chk("stats_count7", 2'd2, 32'd7);
    bus_wr(2'd2, 32'h1234_5678);
    bus_rd_chk("stats_count_clr", 2'd2, 32'd0);
    bus_wr(2'd3, 32'd0);
    for (int i = 1; i <= 9; i++) bus_wr(2'd0, 32'hD000_0000 | 32'(i));
    bus_rd_chk("stats_hwm9", 2'd3, 32'd9);
`else
    for (int i = 1; i <= 3; i++) bus_wr(2'd0, 32'hD000_0000 | 32'(i));
`endif

    // Reset mid-stream discards everything.
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("midrst_tdata", tdata, 32'd0);
    bus_rd_chk("midrst_status", 2'd1, 32'h0000_8000);
`ifdef GRAPHITE_CMD_FIFO_STATS_EN
    bus_rd_chk("midrst_count", 2'd2, 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
